mcash_req_arb: RTL and testbench

Arbitrates the three mcash request channels (ch0..ch2) onto the single mcash pipeline request port and routes pipeline returns back to the originating channel. Round-robin grant, one registered output stage, per-channel outstanding-request limit. Sits between the channel interfaces and the mcash tag/data pipeline inside mcash_top.

---
 rtl/mcash_arb_pkg.sv | 24 ++
 rtl/mcash_rr_pick.sv | 33 +++
 rtl/mcash_req_arb.sv | 177 +++++++++++++++++
 tb/tb_mcash_req_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcash_arb_pkg.sv
// Shared types for the mcash request arbiter: channel ids, opcodes and the request payload.
package mcash_arb_pkg;

    localparam int unsigned CH_NUM = 3;

    typedef logic [1:0] chid_t;
    typedef logic [2:0] op_t;

    typedef struct packed {
        op_t          op;
        logic [27:0]  addr;
        logic [127:0] data;
    } req_t;

    localparam chid_t CHID_ILLEGAL = 2'd3;

    function automatic chid_t onehot_to_chid(input logic [CH_NUM-1:0] oh);
        onehot_to_chid = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (oh[i]) onehot_to_chid = chid_t'(i);
        end
    endfunction

endpackage

// File: rtl/mcash_rr_pick.sv
// Three-way round-robin picker: searches from ptr_i upward (mod 3), returns a one-hot grant
// and the pointer value just past the winner.
module mcash_rr_pick
    import mcash_arb_pkg::*;
(
    input  logic [CH_NUM-1:0] req_i,
    input  chid_t             ptr_i,
    output logic [CH_NUM-1:0] gnt_o,
    output chid_t             ptr_next_o
);

    int unsigned base;
    logic        found;
    chid_t       idx;

    always_comb begin
        gnt_o      = '0;
        ptr_next_o = ptr_i;
        found      = 1'b0;
        idx        = '0;
        // An out-of-range pointer can only come from a corrupted state; restart at channel 0.
        base       = (ptr_i == CHID_ILLEGAL) ? 32'd0 : 32'(ptr_i);
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            idx = chid_t'((base + i) % CH_NUM);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                ptr_next_o = chid_t'((base + i + 1) % CH_NUM);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcash_req_arb.sv
// Round-robin arbiter of three mcash request channels onto one registered pipeline slot,
// with return demux and per-channel outstanding limits. Optional MCASH_ARB_PERF_CNT_EN counters.
module mcash_req_arb
    import mcash_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTD = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ch0_req_valid_i,
    output logic         ch0_req_allowIn_o,
    input  logic [2:0]   ch0_req_op_i,
    input  logic [27:0]  ch0_req_addr_i,
    input  logic [127:0] ch0_req_data_i,
    output logic         ch0_rtn_valid_o,
    input  logic         ch0_rtn_ready_i,
    output logic [127:0] ch0_rtn_data_o,
    input  logic         ch1_req_valid_i,
    output logic         ch1_req_allowIn_o,
    input  logic [2:0]   ch1_req_op_i,
    input  logic [27:0]  ch1_req_addr_i,
    input  logic [127:0] ch1_req_data_i,
    output logic         ch1_rtn_valid_o,
    input  logic         ch1_rtn_ready_i,
    output logic [127:0] ch1_rtn_data_o,
    input  logic         ch2_req_valid_i,
    output logic         ch2_req_allowIn_o,
    input  logic [2:0]   ch2_req_op_i,
    input  logic [27:0]  ch2_req_addr_i,
    input  logic [127:0] ch2_req_data_i,
    output logic         ch2_rtn_valid_o,
    input  logic         ch2_rtn_ready_i,
    output logic [127:0] ch2_rtn_data_o,
    output logic         pipe_req_valid_o,
    input  logic         pipe_req_allowIn_i,
    output logic [2:0]   pipe_req_op_o,
    output logic [27:0]  pipe_req_addr_o,
    output logic [127:0] pipe_req_data_o,
    output logic [1:0]   pipe_req_chid_o,
    input  logic         pipe_rtn_valid_i,
    output logic         pipe_rtn_ready_o,
    input  logic [1:0]   pipe_rtn_chid_i,
    input  logic [127:0] pipe_rtn_data_i,
`ifdef MCASH_ARB_PERF_CNT_EN
    output logic [31:0]  ch0_grant_cnt_o,
    output logic [31:0]  ch1_grant_cnt_o,
    output logic [31:0]  ch2_grant_cnt_o,
    output logic [31:0]  stall_cnt_o,
`endif
    output logic         arb_err_o
);

    logic [CH_NUM-1:0] ch_valid, eligible, pick_req, gnt, ch_rtn_valid, ch_rtn_ready, rtn_hs;
    req_t              ch_req [CH_NUM];
    req_t              sel_req, stage_q;
    logic              stage_valid_q, stage_free, any_gnt, err_q;
    chid_t             stage_chid_q, rr_ptr_q, rr_ptr_next;
    logic [CNT_W-1:0]  outstd_q [CH_NUM];
    logic [CNT_W-1:0]  outstd_d [CH_NUM];

    assign ch_valid     = {ch2_req_valid_i, ch1_req_valid_i, ch0_req_valid_i};
    assign ch_rtn_ready = {ch2_rtn_ready_i, ch1_rtn_ready_i, ch0_rtn_ready_i};
    assign ch_req[0]    = '{op: ch0_req_op_i, addr: ch0_req_addr_i, data: ch0_req_data_i};
    assign ch_req[1]    = '{op: ch1_req_op_i, addr: ch1_req_addr_i, data: ch1_req_data_i};
    assign ch_req[2]    = '{op: ch2_req_op_i, addr: ch2_req_addr_i, data: ch2_req_data_i};

    // The slot can take a new request when empty or being drained this same cycle.
    assign stage_free = !stage_valid_q | pipe_req_allowIn_i;

    always_comb begin
        eligible = '0;
        for (int unsigned n = 0; n < CH_NUM; n++) begin
            eligible[n] = ch_valid[n] & (outstd_q[n] < CNT_W'(MAX_OUTSTD));
        end
    end

    assign pick_req = stage_free ? eligible : '0;

    mcash_rr_pick u_rr_pick (
        .req_i      (pick_req),
        .ptr_i      (rr_ptr_q),
        .gnt_o      (gnt),
        .ptr_next_o (rr_ptr_next)
    );

    assign any_gnt = |gnt;

    always_comb begin
        sel_req = '0;
        for (int unsigned n = 0; n < CH_NUM; n++) begin
            if (gnt[n]) sel_req = ch_req[n];
        end
    end

    always_comb begin
        ch_rtn_valid     = '0;
        rtn_hs           = '0;
        pipe_rtn_ready_o = 1'b1;
        if (pipe_rtn_chid_i != CHID_ILLEGAL) begin
            pipe_rtn_ready_o = ch_rtn_ready[pipe_rtn_chid_i];
        end
        for (int unsigned n = 0; n < CH_NUM; n++) begin
            ch_rtn_valid[n] = pipe_rtn_valid_i & (pipe_rtn_chid_i == chid_t'(n));
            rtn_hs[n]       = ch_rtn_valid[n] & ch_rtn_ready[n];
        end
    end

    // Simultaneous grant and return cancel; a return at zero is a protocol error and is ignored.
    always_comb begin
        for (int unsigned n = 0; n < CH_NUM; n++) begin
            outstd_d[n] = outstd_q[n];
            if (gnt[n] && !(rtn_hs[n] && outstd_q[n] != '0)) begin
                outstd_d[n] = outstd_q[n] + CNT_W'(1);
            end else if (!gnt[n] && rtn_hs[n] && outstd_q[n] != '0) begin
                outstd_d[n] = outstd_q[n] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_valid_q <= 1'b0;
            stage_q       <= '0;
            stage_chid_q  <= '0;
            rr_ptr_q      <= '0;
            err_q         <= 1'b0;
            for (int unsigned n = 0; n < CH_NUM; n++) outstd_q[n] <= '0;
        end else begin
            if (any_gnt) begin
                stage_valid_q <= 1'b1;
                stage_q       <= sel_req;
                stage_chid_q  <= onehot_to_chid(gnt);
                rr_ptr_q      <= rr_ptr_next;
            end else if (pipe_req_allowIn_i) begin
                stage_valid_q <= 1'b0;
            end
            if (pipe_rtn_valid_i && pipe_rtn_chid_i == CHID_ILLEGAL) err_q <= 1'b1;
            for (int unsigned n = 0; n < CH_NUM; n++) outstd_q[n] <= outstd_d[n];
        end
    end

`ifdef MCASH_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt_q [CH_NUM];
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            for (int unsigned n = 0; n < CH_NUM; n++) grant_cnt_q[n] <= '0;
        end else begin
            if (|ch_valid && !any_gnt) stall_cnt_q <= stall_cnt_q + 32'd1;
            for (int unsigned n = 0; n < CH_NUM; n++) begin
                if (gnt[n]) grant_cnt_q[n] <= grant_cnt_q[n] + 32'd1;
            end
        end
    end

    assign ch0_grant_cnt_o = grant_cnt_q[0];
    assign ch1_grant_cnt_o = grant_cnt_q[1];
    assign ch2_grant_cnt_o = grant_cnt_q[2];
    assign stall_cnt_o     = stall_cnt_q;
`endif

    assign {ch2_req_allowIn_o, ch1_req_allowIn_o, ch0_req_allowIn_o} = gnt;
    assign {ch2_rtn_valid_o, ch1_rtn_valid_o, ch0_rtn_valid_o}       = ch_rtn_valid;
    assign ch0_rtn_data_o   = pipe_rtn_data_i;
    assign ch1_rtn_data_o   = pipe_rtn_data_i;
    assign ch2_rtn_data_o   = pipe_rtn_data_i;
    assign pipe_req_valid_o = stage_valid_q;
    assign pipe_req_op_o    = stage_q.op;
    assign pipe_req_addr_o  = stage_q.addr;
    assign pipe_req_data_o  = stage_q.data;
    assign pipe_req_chid_o  = stage_chid_q;
    assign arb_err_o        = err_q;

endmodule

// File: tb/tb_mcash_req_arb.sv
// Randomized scoreboard bench for mcash_req_arb against a queue-based reference model.
module tb_mcash_req_arb;

    localparam int MAXO = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [2:0]   req_valid = '0;
    logic [2:0]   req_op [3];
    logic [27:0]  req_addr [3];
    logic [127:0] req_data [3];
    logic [2:0]   rtn_ready = '0;
    logic         a0, a1, a2, rv0, rv1, rv2;
    logic [127:0] rd0, rd1, rd2;
    logic         pipe_req_valid_o, pipe_req_allowIn_i = 1'b0;
    logic [2:0]   pipe_req_op_o;
    logic [27:0]  pipe_req_addr_o;
    logic [127:0] pipe_req_data_o;
    logic [1:0]   pipe_req_chid_o;
    logic         pipe_rtn_valid_i = 1'b0, pipe_rtn_ready_o;
    logic [1:0]   pipe_rtn_chid_i = '0;
    logic [127:0] pipe_rtn_data_i = '0;
    logic         arb_err_o;
`ifdef MCASH_ARB_PERF_CNT_EN
    logic [31:0]  gc0, gc1, gc2, stc;
`endif

    wire [2:0] req_allow = {a2, a1, a0};
    wire [2:0] rtn_valid = {rv2, rv1, rv0};

    always #5 clk_i = ~clk_i;

    mcash_req_arb #(.MAX_OUTSTD(MAXO), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ch0_req_valid_i(req_valid[0]), .ch0_req_allowIn_o(a0), .ch0_req_op_i(req_op[0]),
        .ch0_req_addr_i(req_addr[0]), .ch0_req_data_i(req_data[0]), .ch0_rtn_valid_o(rv0),
        .ch0_rtn_ready_i(rtn_ready[0]), .ch0_rtn_data_o(rd0),
        .ch1_req_valid_i(req_valid[1]), .ch1_req_allowIn_o(a1), .ch1_req_op_i(req_op[1]),
        .ch1_req_addr_i(req_addr[1]), .ch1_req_data_i(req_data[1]), .ch1_rtn_valid_o(rv1),
        .ch1_rtn_ready_i(rtn_ready[1]), .ch1_rtn_data_o(rd1),
        .ch2_req_valid_i(req_valid[2]), .ch2_req_allowIn_o(a2), .ch2_req_op_i(req_op[2]),
        .ch2_req_addr_i(req_addr[2]), .ch2_req_data_i(req_data[2]), .ch2_rtn_valid_o(rv2),
        .ch2_rtn_ready_i(rtn_ready[2]), .ch2_rtn_data_o(rd2),
        .pipe_req_valid_o(pipe_req_valid_o), .pipe_req_allowIn_i(pipe_req_allowIn_i),
        .pipe_req_op_o(pipe_req_op_o), .pipe_req_addr_o(pipe_req_addr_o),
        .pipe_req_data_o(pipe_req_data_o), .pipe_req_chid_o(pipe_req_chid_o),
        .pipe_rtn_valid_i(pipe_rtn_valid_i), .pipe_rtn_ready_o(pipe_rtn_ready_o),
        .pipe_rtn_chid_i(pipe_rtn_chid_i), .pipe_rtn_data_i(pipe_rtn_data_i),
`ifdef MCASH_ARB_PERF_CNT_EN
        .ch0_grant_cnt_o(gc0), .ch1_grant_cnt_o(gc1), .ch2_grant_cnt_o(gc2), .stall_cnt_o(stc),
`endif
        .arb_err_o(arb_err_o)
    );

    typedef struct {
        int           chid;
        logic [2:0]   op;
        logic [27:0]  addr;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cnt[3];
    int   gcount[3];
    int   rr;
    bit   err;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a pipeline transfer will happen at the coming posedge; pop and compare it.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                chk("pipe_valid", 192'(pipe_req_valid_o), 192'(exp_q.size() != 0));
                if (pipe_req_valid_o && pipe_req_allowIn_i && exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pipe_req", {pipe_req_chid_o, pipe_req_op_o, pipe_req_addr_o,
                        pipe_req_data_o}, {2'(e.chid), e.op, e.addr, e.data});
                end
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        rr  = 0;
        err = 0;
        for (int n = 0; n < 3; n++) begin
            cnt[n]    = 0;
            gcount[n] = 0;
        end
    endtask

    task automatic step(input bit [2:0] vmask, input int pv, input int pallow, input int prtn,
                        input int prdy, input bit bad);
        int   cands[$];
        int   win;
        int   c;
        logic [2:0] exp_allow;
        logic [2:0] exp_rv;
        logic exp_rdy;
        @(posedge clk_i);
        #1;
        for (int n = 0; n < 3; n++) begin
            req_valid[n] = vmask[n] && ($urandom_range(99) < pv);
            req_op[n]    = 3'($urandom);
            req_addr[n]  = 28'($urandom);
            req_data[n]  = {$urandom, $urandom, $urandom, $urandom};
            rtn_ready[n] = $urandom_range(99) < prdy;
            if (cnt[n] > 0) cands.push_back(n);
        end
        pipe_req_allowIn_i = $urandom_range(99) < pallow;
        pipe_rtn_data_i    = {$urandom, $urandom, $urandom, $urandom};
        if (bad) begin
            pipe_rtn_valid_i = 1'b1;
            pipe_rtn_chid_i  = 2'd3;
        end else if (cands.size() != 0 && $urandom_range(99) < prtn) begin
            pipe_rtn_valid_i = 1'b1;
            pipe_rtn_chid_i  = 2'(cands[$urandom_range(cands.size() - 1)]);
        end else begin
            pipe_rtn_valid_i = 1'b0;
            pipe_rtn_chid_i  = 2'($urandom_range(2));
        end
        @(negedge clk_i);
        #1;
        win = -1;
        if (exp_q.size() == 0) begin
            for (int i = 0; i < 3; i++) begin
                c = (rr + i) % 3;
                if (win < 0 && req_valid[c] && cnt[c] < MAXO) win = c;
            end
        end
        exp_allow = (win >= 0) ? 3'(1 << win) : 3'b000;
        chk("req_allowIn", 192'(req_allow), 192'(exp_allow));
        for (int n = 0; n < 3; n++) gcount[n] += int'(req_allow[n]);
        exp_rv  = '0;
        exp_rdy = 1'b1;
        if (pipe_rtn_chid_i != 2'd3) begin
            exp_rv[pipe_rtn_chid_i] = pipe_rtn_valid_i;
            exp_rdy = rtn_ready[pipe_rtn_chid_i];
        end
        chk("rtn_valid", 192'(rtn_valid), 192'(exp_rv));
        chk("rtn_ready", 192'(pipe_rtn_ready_o), 192'(exp_rdy));
        chk("rtn_data", {rd0, rd1[63:0]}, {pipe_rtn_data_i, pipe_rtn_data_i[63:0]});
        chk("rtn_data2", 192'(rd2), 192'(pipe_rtn_data_i));
        chk("arb_err", 192'(arb_err_o), 192'(err));
        if (pipe_rtn_valid_i && pipe_rtn_chid_i == 2'd3) err = 1;
        if (pipe_rtn_valid_i && pipe_rtn_chid_i != 2'd3 && rtn_ready[pipe_rtn_chid_i] &&
            cnt[pipe_rtn_chid_i] > 0) begin
            cnt[pipe_rtn_chid_i]--;
        end
        if (win >= 0) begin
            exp_q.push_back('{chid: win, op: req_op[win], addr: req_addr[win],
                              data: req_data[win]});
            cnt[win]++;
            rr = (win + 1) % 3;
        end
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear before the next edge.
    task automatic do_reset();
        @(posedge clk_i);
        #3;
        rst_ni           = 1'b0;
        req_valid        = '0;
        pipe_rtn_valid_i = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 192'(pipe_req_valid_o), 192'(0));
        chk("rst_payload", {pipe_req_chid_o, pipe_req_op_o, pipe_req_addr_o, pipe_req_data_o},
            192'(0));
        chk("rst_err", 192'(arb_err_o), 192'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        for (int n = 0; n < 3; n++) begin
            req_op[n]   = '0;
            req_addr[n] = '0;
            req_data[n] = '0;
        end
        model_reset();
        do_reset();

        // Full load, instant returns: strict 0,1,2 rotation at one request per cycle.
        for (int i = 0; i < 30; i++) step(3'b111, 100, 100, 100, 100, 1'b0);
        chk("rotation_cnt", 192'(gcount[0] + gcount[1] + gcount[2]), 192'(30));

        // Outstanding limit on ch1 with no returns, then exactly one more grant after a return.
        do_reset();
        for (int i = 0; i < 12; i++) step(3'b010, 100, 100, 0, 100, 1'b0);
        chk("limit_grants", 192'(gcount[1]), 192'(MAXO));
        step(3'b010, 100, 100, 100, 100, 1'b0);
        for (int i = 0; i < 6; i++) step(3'b010, 100, 100, 0, 100, 1'b0);
        chk("limit_plus_one", 192'(gcount[1]), 192'(MAXO + 1));

        // Back-pressured pipeline with ch0 only: single grant held in the slot.
        do_reset();
        for (int i = 0; i < 5; i++) step(3'b001, 100, 0, 0, 100, 1'b0);
        chk("stall_grants", 192'(gcount[0]), 192'(1));

        // Mixed random traffic.
        for (int i = 0; i < 2000; i++) step(3'b111, 60, 60, 50, 60, 1'b0);

        // Illegal return channel: sticky error.
        step(3'b111, 50, 50, 0, 50, 1'b1);
        for (int i = 0; i < 10; i++) step(3'b111, 50, 50, 50, 50, 1'b0);

        // Reset with stage full and counters non-zero; first grant afterwards goes to ch0.
        for (int i = 0; i < 6; i++) step(3'b111, 100, 100, 0, 100, 1'b0);
        for (int i = 0; i < 2; i++) step(3'b111, 100, 0, 0, 100, 1'b0);
        do_reset();
        step(3'b111, 100, 100, 0, 100, 1'b0);
        chk("post_rst_first", 192'(gcount[0]), 192'(1));
        for (int i = 0; i < 20; i++) step(3'b111, 70, 70, 60, 70, 1'b0);

        @(negedge clk_i);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
